seq_csel_subtractor: RTL
========================

SEQ_CSEL_SUBTRACTOR -- requirements
Module: seq_csel_subtractor

Interface
REQ-001 Parameter: N, default 32, operand/result width; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 x  input  N  minuend.
REQ-005 y  input  N  subtrahend.
REQ-006 borrowin  input  1  borrow into bit 0.
REQ-007 in_valid  input  1  operands present this cycle.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 diff  output  N  registered result, x - y - borrowin mod 2^N.
REQ-010 borrowout  output  1  unsigned borrow out of bit N-1.
REQ-011 overflow  output  1  two's-complement overflow of the subtraction.
REQ-012 out_valid  output  1  diff/borrowout/overflow valid.
REQ-013 out_ready  input  1  consumer accepts result.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 Accept occurs on an edge with in_valid=1 and in_ready=1: latch x, y and borrowin, clear the slice index to 0, go to RUN.
REQ-017 In RUN, each cycle SHALL process one 4-bit slice k = index, bits [4k+3:4k], LSB slice first.
REQ-018 Each slice SHALL precompute both results, for borrow-in 0 and 1, as a + ~b + 1 and a + ~b respectively, then select on the registered borrow from the previous slice.
REQ-019 Slice 0 borrow-in SHALL be the latched borrowin.
REQ-020 On each RUN edge, the slice result SHALL be written into diff[4k+3:4k], the borrow register updated, and the index incremented.
REQ-021 After slice N/4-1 is written, the state SHALL go to DONE.
REQ-022 out_valid SHALL rise exactly N/4 edges after the accept edge (8 for N=32).
REQ-023 borrowout SHALL be 1 exactly when x < y + borrowin, compared as unsigned values.
REQ-024 overflow SHALL equal (x[N-1]^y[N-1]) & (x[N-1]^diff[N-1]), using the latched operands.
REQ-025 borrowout and overflow SHALL be updated on the same edge as the final slice.
REQ-026 In DONE, diff, borrowout and overflow SHALL hold stable while out_ready=0, for unbounded backpressure.
REQ-027 On an edge with out_valid=1 and out_ready=1, the state SHALL go to IDLE.
REQ-028 in_ready SHALL not be asserted before that edge, so there is no same-cycle result/operand overlap.
REQ-029 diff, borrowout and overflow SHALL retain the last result after return to IDLE until the final slice of the next operation.
REQ-030 In_valid outside IDLE SHALL be ignored, and x/y changes after acceptance SHALL not affect the result.
REQ-031 out_ready outside DONE SHALL be ignored.

Reset
REQ-032 Asserting rst SHALL immediately set state=IDLE, index=0, borrow register=0, diff=0, borrowout=0, overflow=0, out_valid=0 and in_ready=1, without waiting for clk.
REQ-033 Reset during RUN or DONE SHALL abort and discard the operation; no out_valid SHALL follow for it.
REQ-034 After rst deasserts, the first rising edge SHALL be able to accept operands.

Verification (N=32)
REQ-035 x=5, y=3, borrowin=0 -> after 8 edges out_valid=1, diff=0x00000002, borrowout=0, overflow=0.
REQ-036 x=0, y=1, borrowin=0 -> diff=0xFFFFFFFF, borrowout=1, overflow=0; x=0, y=0, borrowin=1 -> same result.
REQ-037 x=0x80000000, y=1 -> diff=0x7FFFFFFF, borrowout=0, overflow=1; x=0x7FFFFFFF, y=0xFFFFFFFF -> diff=0x80000000, borrowout=1, overflow=1.
REQ-038 Borrow ripple across all slices: x=0x10000000, y=0x00000001 -> diff=0x0FFFFFFF, borrowout=0.
  - Hold out_ready=0 for 5 cycles: outputs stable and in_ready=0 throughout.
  - Toggling in_valid during RUN: no effect.
REQ-039 Assert rst at RUN cycle 4, asynchronously and mid-cycle -> outputs zero and in_ready=1 immediately, out_valid never rises.
  - Then x=9, y=4 -> diff=0x00000005 after 8 edges.
REQ-040 Random regression of 10k operand triples with random out_ready stalls -> every result matches the 33-bit reference computation of x - y - borrowin and the overflow formula.

Source files
------------

// File: rtl/seq_csel_subtractor.sv
// seq_csel_subtractor: sequential carry-select subtractor.
// Operands are accepted in IDLE. RUN then processes one 4-bit slice per clock,
// LSB slice first. Each slice precomputes both borrow-in results and selects
// one with the registered borrow from the previous slice. The full result,
// borrowout and overflow appear together on the final-slice edge and are held
// in DONE until out_ready. N must be a multiple of 4 and at least 4.
module seq_csel_subtractor #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         borrowin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] diff,
    output logic         borrowout,
    output logic         overflow,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int NSLICE = N / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control state
    state_t           state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             borrow_q,    borrow_d;

    // Latched operands, so later changes on x/y cannot disturb the operation
    logic [N-1:0]     x_q,         x_d;
    logic [N-1:0]     y_q,         y_d;

    // Partial result built one slice per RUN cycle. It is kept apart from
    // diff_q so the visible result keeps the previous answer until the
    // final slice of the next operation lands.
    logic [N-1:0]     acc_q,       acc_d;

    // Registered outputs
    logic [N-1:0]     diff_q,      diff_d;
    logic             borrowout_q, borrowout_d;
    logic             overflow_q,  overflow_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Slice datapath
    logic [3:0]       a_slice;
    logic [3:0]       b_slice;
    logic [4:0]       sum_bin0;
    logic [4:0]       sum_bin1;
    logic [4:0]       slice_sum;
    logic [3:0]       slice_res;
    logic             slice_borrow;
    logic [N-1:0]     acc_merged;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrowout = borrowout_q;
    assign overflow  = overflow_q;

    // Pick the 4-bit operand slices addressed by the current slice index
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_slice = x_q[4*k +: 4];
                b_slice = y_q[4*k +: 4];
            end
        end
    end

    // Carry-select slice: both borrow-in cases computed, registered borrow selects
    always_comb begin
        // a - b - 0 = a + ~b + 1 ; a - b - 1 = a + ~b
        sum_bin0     = {1'b0, a_slice} + {1'b0, ~b_slice} + 5'd1;
        sum_bin1     = {1'b0, a_slice} + {1'b0, ~b_slice};
        slice_sum    = borrow_q ? sum_bin1 : sum_bin0;
        slice_res    = slice_sum[3:0];
        // No carry out of the slice means the slice had to borrow
        slice_borrow = ~slice_sum[4];
    end

    // Merge the fresh slice result into the partial result at the current index
    always_comb begin
        acc_merged = acc_q;
        for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                acc_merged[4*k +: 4] = slice_res;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        borrow_d    = borrow_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        diff_d      = diff_q;
        borrowout_d = borrowout_q;
        overflow_d  = overflow_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = x;
                    y_d        = y;
                    borrow_d   = borrowin;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end

            RUN: begin
                acc_d    = acc_merged;
                borrow_d = slice_borrow;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    diff_d      = acc_merged;
                    borrowout_d = slice_borrow;
                    // The top slice's bit 3 is diff[N-1] of the new result
                    overflow_d  = (x_q[N-1] ^ y_q[N-1]) & (x_q[N-1] ^ slice_res[3]);
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                idx_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once, without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            borrow_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            diff_q      <= '0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            borrow_q    <= borrow_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            borrowout_q <= borrowout_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
